// File: rtl/vc_credit_sender.sv
// Credit-based sender: turns a val/rdy stream into single-cycle send strobes,
// never issuing more messages than the downstream buffer has free slots.
module vc_credit_sender #(
    parameter  int p_msg_nbits    = 32,
    parameter  int p_num_credits  = 4,
    localparam int p_credit_nbits = $clog2(p_num_credits + 1)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_val,
    output logic                      in_rdy,
    input  logic [p_msg_nbits-1:0]    in_msg,
    output logic                      out_val,
    output logic [p_msg_nbits-1:0]    out_msg,
    input  logic                      credit_return,
    output logic [p_credit_nbits-1:0] credits,
    output logic                      credits_is_zero,
    output logic                      credits_is_max,
    output logic                      overflow_err
);

    localparam logic [p_credit_nbits-1:0] c_max = p_credit_nbits'(p_num_credits);
    localparam logic [p_credit_nbits-1:0] c_one = p_credit_nbits'(1);

    logic [p_credit_nbits-1:0] r_credits;
    logic                      r_out_val;
    logic [p_msg_nbits-1:0]    r_out_msg;
    logic                      r_overflow_err;

    logic                      w_send;
    logic                      w_at_max;
    logic [p_credit_nbits-1:0] w_credits_next;
    logic                      w_overflow_next;

    // Ready depends only on registered credits, so a return this cycle cannot
    // open the gate until the next cycle.
    assign w_at_max = (r_credits == c_max);
    assign in_rdy   = reset_n & (r_credits != '0);
    assign w_send   = in_val & in_rdy;

    always_comb begin
        w_credits_next  = r_credits;
        w_overflow_next = r_overflow_err;
        unique case ({w_send, credit_return})
            2'b10:   w_credits_next = r_credits - c_one;
            2'b01: begin
                // A return with no outstanding message is a protocol error.
                if (w_at_max) w_overflow_next = 1'b1;
                else          w_credits_next  = r_credits + c_one;
            end
            default: w_credits_next = r_credits;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_credits      <= c_max;
            r_out_val      <= 1'b0;
            r_out_msg      <= '0;
            r_overflow_err <= 1'b0;
        end else begin
            r_credits      <= w_credits_next;
            r_out_val      <= w_send;
            r_overflow_err <= w_overflow_next;
            if (w_send) r_out_msg <= in_msg;
        end
    end

    assign out_val         = r_out_val;
    assign out_msg         = r_out_msg;
    assign credits         = r_credits;
    assign credits_is_zero = (r_credits == '0);
    assign credits_is_max  = w_at_max;
    assign overflow_err    = r_overflow_err;

endmodule

// File: tb/tb_vc_credit_sender.sv
// Directed bench for vc_credit_sender with 4 credits and 32-bit messages.
module tb_vc_credit_sender;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_val;
    logic        in_rdy;
    logic [31:0] in_msg;
    logic        out_val;
    logic [31:0] out_msg;
    logic        credit_return;
    logic [2:0]  credits;
    logic        credits_is_zero;
    logic        credits_is_max;
    logic        overflow_err;

    int err_cnt = 0;
    int chk_cnt = 0;

    vc_credit_sender #(.p_msg_nbits(32), .p_num_credits(4)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_val          (in_val),
        .in_rdy          (in_rdy),
        .in_msg          (in_msg),
        .out_val         (out_val),
        .out_msg         (out_msg),
        .credit_return   (credit_return),
        .credits         (credits),
        .credits_is_zero (credits_is_zero),
        .credits_is_max  (credits_is_max),
        .overflow_err    (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_val = 1'b0; in_msg = '0; credit_return = 1'b0;
        #2;
        chk_cnt++; if (in_rdy !== 1'b0) begin err_cnt++; $display("FAIL reset_rdy_low got=%b exp=0", in_rdy); end
        step(); step();
        chk_cnt++; if (credits !== 3'd4) begin err_cnt++; $display("FAIL reset_credits got=%0d exp=4", credits); end
        chk_cnt++; if (credits_is_max !== 1'b1) begin err_cnt++; $display("FAIL reset_is_max got=%b exp=1", credits_is_max); end
        chk_cnt++; if (out_val !== 1'b0) begin err_cnt++; $display("FAIL reset_out_val got=%b exp=0", out_val); end
        chk_cnt++; if (in_rdy !== 1'b0) begin err_cnt++; $display("FAIL reset_rdy_held got=%b exp=0", in_rdy); end
        chk_cnt++; if (overflow_err !== 1'b0) begin err_cnt++; $display("FAIL reset_ovf got=%b exp=0", overflow_err); end
        reset_n = 1'b1;
        #1;
        chk_cnt++; if (in_rdy !== 1'b1) begin err_cnt++; $display("FAIL release_rdy got=%b exp=1", in_rdy); end
        $display("reset: credits=%0d in_rdy=%b", credits, in_rdy);
    endtask

    task automatic test_burst();
        logic [31:0] msgs [5] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4};
        logic [2:0]  exp_cr [4] = '{3'd3, 3'd2, 3'd1, 3'd0};
        in_val = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_msg = msgs[k];
            step();
            chk_cnt++; if (out_val !== 1'b1 || out_msg !== msgs[k]) begin err_cnt++; $display("FAIL burst_out%0d got=%b/%h exp=1/%h", k, out_val, out_msg, msgs[k]); end
            chk_cnt++; if (credits !== exp_cr[k]) begin err_cnt++; $display("FAIL burst_credits%0d got=%0d exp=%0d", k, credits, exp_cr[k]); end
            $display("burst send msg=%h credits=%0d", out_msg, credits);
        end
        chk_cnt++; if (credits_is_zero !== 1'b1) begin err_cnt++; $display("FAIL burst_is_zero got=%b exp=1", credits_is_zero); end
        chk_cnt++; if (in_rdy !== 1'b0) begin err_cnt++; $display("FAIL burst_rdy got=%b exp=0", in_rdy); end
        in_msg = msgs[4];
        step();
        chk_cnt++; if (out_val !== 1'b0 || out_msg !== 32'hA3) begin err_cnt++; $display("FAIL burst_held got=%b/%h exp=0/000000a3", out_val, out_msg); end
        chk_cnt++; if (credits !== 3'd0) begin err_cnt++; $display("FAIL burst_held_credits got=%0d exp=0", credits); end
        $display("burst held msg=%h upstream", in_msg);
    endtask

    task automatic test_return_unblocks();
        in_val = 1'b1; in_msg = 32'hA4; credit_return = 1'b1;
        step();
        credit_return = 1'b0;
        chk_cnt++; if (credits !== 3'd1 || in_rdy !== 1'b1) begin err_cnt++; $display("FAIL ret_credit got=%0d/%b exp=1/1", credits, in_rdy); end
        chk_cnt++; if (out_val !== 1'b0) begin err_cnt++; $display("FAIL ret_no_bypass got=%b exp=0", out_val); end
        step();
        in_val = 1'b0;
        chk_cnt++; if (out_val !== 1'b1 || out_msg !== 32'hA4) begin err_cnt++; $display("FAIL ret_send got=%b/%h exp=1/000000a4", out_val, out_msg); end
        chk_cnt++; if (credits !== 3'd0) begin err_cnt++; $display("FAIL ret_credits got=%0d exp=0", credits); end
        $display("return: sent msg=%h credits=%0d", out_msg, credits);
    endtask

    task automatic test_simultaneous();
        in_val = 1'b0; credit_return = 1'b1;
        step(); step();
        chk_cnt++; if (credits !== 3'd2) begin err_cnt++; $display("FAIL sim_setup got=%0d exp=2", credits); end
        in_val = 1'b1; in_msg = 32'h55;
        step();
        chk_cnt++; if (credits !== 3'd2 || out_val !== 1'b1 || out_msg !== 32'h55) begin err_cnt++; $display("FAIL sim_mid got=%0d/%b/%h exp=2/1/00000055", credits, out_val, out_msg); end
        $display("simultaneous @2: msg=%h credits=%0d", out_msg, credits);
        in_val = 1'b0;
        step(); step();
        chk_cnt++; if (credits !== 3'd4 || credits_is_max !== 1'b1) begin err_cnt++; $display("FAIL sim_refill got=%0d/%b exp=4/1", credits, credits_is_max); end
        in_val = 1'b1; in_msg = 32'h66;
        step();
        in_val = 1'b0; credit_return = 1'b0;
        chk_cnt++; if (credits !== 3'd4 || overflow_err !== 1'b0) begin err_cnt++; $display("FAIL sim_max got=%0d/%b exp=4/0", credits, overflow_err); end
        chk_cnt++; if (out_val !== 1'b1 || out_msg !== 32'h66) begin err_cnt++; $display("FAIL sim_max_out got=%b/%h exp=1/00000066", out_val, out_msg); end
        $display("simultaneous @4: msg=%h credits=%0d", out_msg, credits);
    endtask

    task automatic test_overflow();
        credit_return = 1'b1;
        step();
        credit_return = 1'b0;
        chk_cnt++; if (credits !== 3'd4 || overflow_err !== 1'b1) begin err_cnt++; $display("FAIL ovf_set got=%0d/%b exp=4/1", credits, overflow_err); end
        for (int k = 0; k < 10; k++) begin
            step();
            chk_cnt++; if (overflow_err !== 1'b1) begin err_cnt++; $display("FAIL ovf_sticky%0d got=%b exp=1", k, overflow_err); end
        end
        $display("overflow: flag=%b credits=%0d", overflow_err, credits);
    endtask

    task automatic test_async_reset();
        in_val = 1'b1; in_msg = 32'h77;
        step(); step(); step();
        in_val = 1'b0;
        chk_cnt++; if (credits !== 3'd1 || out_val !== 1'b1) begin err_cnt++; $display("FAIL async_setup got=%0d/%b exp=1/1", credits, out_val); end
        #2;
        reset_n = 1'b0;
        #1;
        chk_cnt++; if (out_val !== 1'b0 || credits !== 3'd4) begin err_cnt++; $display("FAIL async_clear got=%b/%0d exp=0/4", out_val, credits); end
        chk_cnt++; if (overflow_err !== 1'b0 || out_msg !== 32'h0) begin err_cnt++; $display("FAIL async_ovf_msg got=%b/%h exp=0/00000000", overflow_err, out_msg); end
        chk_cnt++; if (in_rdy !== 1'b0) begin err_cnt++; $display("FAIL async_rdy got=%b exp=0", in_rdy); end
        $display("async reset: credits=%0d out_val=%b", credits, out_val);
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_burst();
        test_return_unblocks();
        test_simultaneous();
        test_overflow();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/vc_credit_sender.md
Name: vc_credit_sender

Overview:
Upstream companion of the saturating up/down counter. It converts a val/rdy message stream into a credit-based send interface. An internal credit counter is preloaded with the downstream buffer depth, decremented on each send and incremented on each credit return pulse. The block sits in front of any credit-managed buffer (e.g. a network or memory request queue) and guarantees the buffer never overflows.

Parameters:
p_msg_nbits, 32, message width in bits
p_num_credits, 4, downstream buffer depth; reset and maximum credit value; must be >= 1
p_credit_nbits, $clog2(p_num_credits+1), derived width of the credit count (not overridden by users)

Ports:
clk  input  1  clock; all state updates on posedge
reset_n  input  1  asynchronous, active-low reset
in_val  input  1  upstream message valid
in_rdy  output  1  upstream ready
in_msg  input  p_msg_nbits  upstream message
out_val  output  1  registered send strobe; one-cycle pulse per message
out_msg  output  p_msg_nbits  registered message, meaningful only when out_val=1
credit_return  input  1  one-cycle pulse; downstream freed one slot
credits  output  p_credit_nbits  currently available credits
credits_is_zero  output  1  credits == 0
credits_is_max  output  1  credits == p_num_credits
overflow_err  output  1  sticky protocol-error flag

Behaviour:
- Reset (reset_n=0, asynchronous, no clock edge required):
  - credits=p_num_credits, out_val=0, out_msg=0, overflow_err=0.
  - in_rdy is forced to 0 while reset_n=0.
  - Any message in the output register is discarded; downstream must be reset together with this block.
- in_rdy = reset_n & (credits != 0). Purely combinational from registered state.
- A credit returned in the current cycle does not raise in_rdy in that same cycle; there is no bypass.
- Transfer: occurs when in_val & in_rdy at a posedge.
  - Next cycle out_val=1 and out_msg=in_msg.
  - Latency is exactly 1 cycle.
  - With no transfer, out_val=0 next cycle and out_msg holds its last value.
- There is no backpressure on out_*; credits guarantee downstream space.
- Credit update at each posedge, with send = in_val & in_rdy and ret = credit_return:
  - send & !ret: credits-1. Cannot underflow because in_rdy=0 at 0.
  - !send & ret: credits+1, saturating at p_num_credits.
  - send & ret: credits unchanged. This is legal even at credits=p_num_credits.
  - !send & !ret: unchanged.
- Overflow:
  - ret & !send while credits==p_num_credits is a protocol violation.
  - credits stays at p_num_credits and overflow_err is set to 1 at that edge.
  - overflow_err is sticky; only reset_n clears it.
- credits_is_zero and credits_is_max are combinational decodes of the credits register.
- Back-to-back sends are allowed every cycle while credits > 0; throughput is 1 message/cycle.
- No X propagation: out_msg is loaded only on a transfer.

Test Plan:
- Reset with p_num_credits=4: hold reset_n=0 for 2 cycles -> credits=4, credits_is_max=1, out_val=0, in_rdy=0 during reset; in_rdy=1 after release.
- Burst: in_val=1 with msgs 0xA0,0xA1,0xA2,0xA3,0xA4 on consecutive cycles, no returns -> out_val=1 with 0xA0..0xA3 on the following 4 cycles; credits 3,2,1,0; credits_is_zero=1; in_rdy=0; 0xA4 held upstream.
- Return unblocks: credits=0, in_val=1 (0xA4), pulse credit_return -> next cycle credits=1 and in_rdy=1; 0xA4 sent; credits back to 0; out_val=1 with 0xA4 one cycle after the transfer.
- Simultaneous: credits=2, send 0x55 with credit_return=1 in the same cycle -> credits stays 2, out_val=1 with 0x55; repeat at credits=4 -> credits stays 4, overflow_err=0.
- Overflow: credits=4, credit_return=1, in_val=0 -> credits stays 4, overflow_err=1; it stays 1 across 10 further idle cycles until reset_n=0.
- Async reset mid-stream: credits=1 and out_val=1, drop reset_n between clock edges -> out_val=0 and credits=4 immediately, with no posedge in between; overflow_err=0.
